// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the two-source interrupt controller:
// register offsets, source indices and the register-select decode.
package irq_ctrl_pkg;

  localparam int NUM_SRC   = 2;
  localparam int SRC_TIMER = 0;
  localparam int SRC_EXT   = 1;

  localparam logic [3:0] OFF_MASK    = 4'h0;
  localparam logic [3:0] OFF_PENDING = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_SET     = 4'hC;

  typedef enum logic [1:0] {
    REG_MASK    = 2'd0,
    REG_PENDING = 2'd1,
    REG_STATUS  = 2'd2,
    REG_SET     = 2'd3
  } reg_sel_e;

  // Only the word index of the byte address selects a register.
  function automatic reg_sel_e decode_addr(input logic [3:0] addr);
    return reg_sel_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for one asynchronous interrupt line.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Two-source interrupt controller: synchronized edge/level capture, ack
// handshake with in-service tracking, fixed priority and a small register file.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [NUM_SRC-1:0] IRQ_EDGE    = 2'b11,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_src,
  input  logic [NUM_SRC-1:0]  interrupt_ack,
  input  logic                dec_mret,
  input  logic                reg_wr_en,
  input  logic                reg_rd_en,
  input  logic [3:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic [NUM_SRC-1:0]  interrupt_enable,
  output logic                irq_active
);

  logic [NUM_SRC-1:0] sync_s;
  logic [NUM_SRC-1:0] sync_prev_q;
  logic [NUM_SRC-1:0] set_evt;
  logic [NUM_SRC-1:0] ack_prev_q;
  logic [NUM_SRC-1:0] ack_edge;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_SRC-1:0] pend_w1c, ovf_w1c, sw_set;
  reg_sel_e           sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (irq_src[gi]),
        .q_o   (sync_s[gi])
      );
      if (IRQ_EDGE[gi]) begin : g_edge
        assign set_evt[gi] = sync_s[gi] & ~sync_prev_q[gi];
      end else begin : g_level
        assign set_evt[gi] = sync_s[gi];
      end
    end
  endgenerate

  assign ack_edge = interrupt_ack & ~ack_prev_q;
  assign sel      = decode_addr(reg_addr);

  always_comb begin
    pend_w1c = '0;
    ovf_w1c  = '0;
    sw_set   = '0;
    mask_d   = mask_q;
    if (reg_wr_en) begin
      case (sel)
        REG_MASK:    mask_d   = reg_wdata[NUM_SRC-1:0];
        REG_PENDING: pend_w1c = reg_wdata[NUM_SRC-1:0];
        REG_STATUS:  ovf_w1c  = reg_wdata[3:2];
        REG_SET:     sw_set   = reg_wdata[NUM_SRC-1:0];
        default:     ;
      endcase
    end
    // Set events are OR'd in last so they win over a same-cycle clear.
    pending_d    = (pending_q & ~(ack_edge | pend_w1c)) | set_evt | sw_set;
    ovf_d        = (ovf_q & ~ovf_w1c) | (set_evt & pending_q);
    in_service_d = (dec_mret ? '0 : in_service_q) | ack_edge;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd_en) begin
      case (sel)
        REG_MASK:    rdata_d = {30'd0, mask_q};
        REG_PENDING: rdata_d = {30'd0, pending_q};
        REG_STATUS:  rdata_d = {28'd0, ovf_q, in_service_q};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_prev_q  <= '0;
      ack_prev_q   <= '0;
      pending_q    <= '0;
      ovf_q        <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      rdata_q      <= '0;
    end else begin
      sync_prev_q  <= sync_s;
      ack_prev_q   <= interrupt_ack;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      rdata_q      <= rdata_d;
    end
  end

  // Request outputs decode registered state only; source 0 wins ties.
  assign interrupt_enable[SRC_TIMER] = pending_q[SRC_TIMER] & mask_q[SRC_TIMER] & ~|in_service_q;
  assign interrupt_enable[SRC_EXT]   = pending_q[SRC_EXT] & mask_q[SRC_EXT] & ~|in_service_q
                                       & ~interrupt_enable[SRC_TIMER];
  assign irq_active = |in_service_q;
  assign reg_rdata  = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{reg_wdata[31:4], reg_addr[1:0]};

endmodule
